// File: rtl/csr_ctrl.sv
// Sequencer in front of the machine-mode CSR register file: runs CSRRW/S/C, ECALL and MRET
// as short multi-cycle sequences over the file's single read and write ports.
module csr_ctrl #(
    parameter logic [63:0] ECALL_CAUSE  = 64'd11,
    parameter bit          CSR_REDIRECT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [11:0] req_csr,
    input  logic [63:0] req_operand,
    input  logic        req_src_zero,
    input  logic [63:0] req_pc,
    output logic [11:0] csr_addr_read,
    input  logic [63:0] csr_rdata,
    output logic [11:0] csr_addr_write,
    output logic [63:0] csr_wdata,
    output logic        csr_we,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_redirect,
    output logic [63:0] resp_target
);
    localparam logic [11:0] MSTATUS = 12'h300;
    localparam logic [11:0] MTVEC   = 12'h305;
    localparam logic [11:0] MEPC    = 12'h341;
    localparam logic [11:0] MCAUSE  = 12'h342;

    typedef enum logic [3:0] {
        IDLE, CSR_EXEC, EC_EPC, EC_CAUSE, EC_STATUS, EC_VEC, MR_STATUS, MR_EPC, RESP
    } state_t;

    state_t      r_state, w_next;
    logic [2:0]  r_op;
    logic [11:0] r_csr;
    logic [63:0] r_operand;
    logic        r_src_zero;
    logic [63:0] r_pc;
    logic        r_resp_valid, r_resp_redirect;
    logic [63:0] r_resp_rdata, r_resp_target;
    logic        w_accept, w_we, w_redirect;
    logic [63:0] w_rdata, w_target;

    function automatic logic [63:0] csr_wval(input logic [2:0] op, input logic [63:0] old,
                                             input logic [63:0] operand);
        case (op)
            3'd1:    return old | operand;
            3'd2:    return old & ~operand;
            default: return operand;
        endcase
    endfunction

    // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- M.
    function automatic logic [63:0] ecall_status(input logic [63:0] s);
        logic [63:0] v;
        v        = s;
        v[7]     = s[3];
        v[3]     = 1'b0;
        v[12:11] = 2'b11;
        return v;
    endfunction

    function automatic logic [63:0] mret_status(input logic [63:0] s);
        logic [63:0] v;
        v        = s;
        v[3]     = s[7];
        v[7]     = 1'b1;
        v[12:11] = 2'b00;
        return v;
    endfunction

    assign w_accept  = req_valid && (r_state == IDLE);
    assign req_ready = (r_state == IDLE);

    always_comb begin
        w_next         = r_state;
        csr_addr_read  = '0;
        csr_addr_write = '0;
        csr_wdata      = '0;
        w_we           = 1'b0;
        w_rdata        = '0;
        w_redirect     = 1'b0;
        w_target       = '0;
        unique case (r_state)
            IDLE: begin
                if (req_valid) begin
                    case (req_op)
                        3'd0, 3'd1, 3'd2: w_next = CSR_EXEC;
                        3'd3:             w_next = EC_EPC;
                        3'd4:             w_next = MR_STATUS;
                        default:          w_next = RESP;
                    endcase
                end
            end
            CSR_EXEC: begin
                csr_addr_read  = r_csr;
                csr_addr_write = r_csr;
                csr_wdata      = csr_wval(r_op, csr_rdata, r_operand);
                w_we           = (r_op == 3'd0) || !r_src_zero;
                w_rdata        = csr_rdata;
                w_redirect     = CSR_REDIRECT;
                w_target       = r_pc + 64'd4;
                w_next         = RESP;
            end
            EC_EPC: begin
                csr_addr_write = MEPC;
                csr_wdata      = r_pc;
                w_we           = 1'b1;
                w_next         = EC_CAUSE;
            end
            EC_CAUSE: begin
                csr_addr_write = MCAUSE;
                csr_wdata      = ECALL_CAUSE;
                w_we           = 1'b1;
                w_next         = EC_STATUS;
            end
            EC_STATUS: begin
                csr_addr_read  = MSTATUS;
                csr_addr_write = MSTATUS;
                csr_wdata      = ecall_status(csr_rdata);
                w_we           = 1'b1;
                w_next         = EC_VEC;
            end
            EC_VEC: begin
                // Synchronous exception always enters at the base, even in vectored mode.
                csr_addr_read = MTVEC;
                w_redirect    = 1'b1;
                w_target      = csr_rdata & ~64'h3;
                w_next        = RESP;
            end
            MR_STATUS: begin
                csr_addr_read  = MSTATUS;
                csr_addr_write = MSTATUS;
                csr_wdata      = mret_status(csr_rdata);
                w_we           = 1'b1;
                w_next         = MR_EPC;
            end
            MR_EPC: begin
                csr_addr_read = MEPC;
                w_redirect    = 1'b1;
                w_target      = csr_rdata;
                w_next        = RESP;
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // A reset landing mid-sequence must not let the current state's write through.
    assign csr_we = w_we && reset;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state         <= IDLE;
            r_op            <= '0;
            r_csr           <= '0;
            r_operand       <= '0;
            r_src_zero      <= 1'b0;
            r_pc            <= '0;
            r_resp_valid    <= 1'b0;
            r_resp_rdata    <= '0;
            r_resp_redirect <= 1'b0;
            r_resp_target   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op       <= req_op;
                r_csr      <= req_csr;
                r_operand  <= req_operand;
                r_src_zero <= req_src_zero;
                r_pc       <= req_pc;
            end
            r_resp_valid    <= (w_next == RESP);
            r_resp_rdata    <= (w_next == RESP) ? w_rdata : '0;
            r_resp_redirect <= (w_next == RESP) && w_redirect;
            r_resp_target   <= (w_next == RESP) ? w_target : '0;
        end
    end

    assign resp_valid    = r_resp_valid;
    assign resp_rdata    = r_resp_rdata;
    assign resp_redirect = r_resp_redirect;
    assign resp_target   = r_resp_target;
endmodule
